dmem_mmio_responder: RTL
========================

Name: dmem_mmio_responder

Overview:
- Responder on the processor's dmem port, placed between the processor and the dmem syncram.
- Decodes each dmem access. Addresses at or above MMIO_BASE go to a small memory-mapped register set; all other accesses pass through to the RAM.
- The register set holds:
  - a free-running cycle counter;
  - a one-shot down-timer with interrupt;
  - an 8-bit transmit FIFO drained by a valid/ready byte consumer.
- MMIO read latency matches the syncram, so the processor sees one uniform dmem timing.

Parameters:
- MMIO_BASE, 12'hF00: first word address decoded as MMIO. Addresses MMIO_BASE..12'hFFF are MMIO space.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of two, 2..16.

Ports:
- clock  in  1  system clock, same clock that drives the dmem syncram.
- reset  in  1  synchronous, active-high reset.
- address_dmem  in  12  word address from the processor.
- data  in  32  write data from the processor.
- wren  in  1  write enable from the processor.
- q_dmem  out  32  read data returned to the processor.
- ram_address  out  12  to syncram address.
- ram_data  out  32  to syncram data.
- ram_wren  out  1  to syncram write enable.
- ram_q  in  32  from syncram q.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head byte this cycle.
- irq  out  1  timer interrupt pending.

Behaviour:
- Decode and RAM pass-through
  - is_mmio = (address_dmem >= MMIO_BASE).
  - ram_address = address_dmem; ram_data = data (both combinational).
  - ram_wren = wren & ~is_mmio. MMIO writes never reach the RAM.
- Read path, 1-cycle latency
  - At each clock edge, sel_q <= is_mmio and mmio_q <= the selected register value.
  - q_dmem = sel_q ? mmio_q : ram_q.
  - An address presented before edge N produces data after edge N, for RAM and MMIO alike.
- Register map (offsets from MMIO_BASE)
  - +0 CYCLE, RO
    - 32-bit counter; increments every clock; wraps FFFFFFFF->0.
    - A read returns the value held before edge N. Writes are ignored.
  - +1 TIMER, RW
    - A write loads data.
    - Otherwise, if nonzero, decrements by 1 each cycle.
    - On the 1->0 transition it sets irq_pending.
    - A write in the same cycle takes precedence: value loaded, no expiry that cycle.
    - Writing 0 stops the timer without setting pending.
  - +2 STATUS
    - Bit 0 irq_pending, W1C.
    - Bit 1 fifo_full, RO.
    - Bit 2 fifo_empty, RO.
    - Bit 3 overflow sticky, W1C.
    - Bits [8:4] fifo count, RO.
    - All other bits read 0.
    - If a set and a W1C clear land in the same cycle, the set wins.
  - +3 TX, WO
    - A write pushes data[7:0] into the FIFO.
    - A read returns 0.
  - All other MMIO offsets read 0; writes there are ignored.
- TX FIFO
  - Circular buffer with read and write pointers plus a count. Pointers wrap at FIFO_DEPTH.
  - tx_data = head entry; tx_valid = (count != 0).
  - Pop occurs when tx_valid & tx_ready.
  - Push is accepted when (count < FIFO_DEPTH) or a pop happens in the same cycle.
  - Simultaneous push and pop: count unchanged.
  - A push rejected while full drops the byte and sets overflow. Count and contents are unchanged.
  - When empty, tx_data holds the last value and tx_valid = 0. The consumer must ignore tx_data.
- irq = irq_pending (registered, level).
- Reset (synchronous; applies mid-operation too):
  - CYCLE = 0, TIMER = 0, irq_pending = 0, overflow = 0.
  - FIFO flushed: count = 0, pointers = 0.
  - sel_q = 0, mmio_q = 0.
  - Resulting outputs: tx_valid = 0, irq = 0, q_dmem follows ram_q.
  - Any access in the reset cycle is ignored by MMIO state.

Test Plan:
- Reset, then 3 idle cycles, then read +0 -> q_dmem = 3 one cycle after the address. irq = 0 and tx_valid = 0 throughout reset.
- Write 0x55 to RAM addr 0x010, read it back -> ram_wren = 1 for the write and q_dmem = 0x55. Write 0xAA to 0xF01 -> ram_wren stays 0.
- Write TIMER = 5 -> irq rises exactly 5 cycles after the write edge. Write STATUS = 1 -> irq = 0 next cycle. Repeat with the clear landing on the expiry cycle -> irq stays 1.
- Hold tx_ready = 0 and write 0x41..0x49 (9 bytes) to TX -> STATUS reads count = 8, full = 1, overflow = 1. Raise tx_ready -> bytes 0x41..0x48 appear in order, then tx_valid = 0 and empty = 1.
- FIFO full with tx_ready = 1 while writing 0x5A -> push accepted, no overflow, count stays 8, 0x5A is delivered last.
- Assert reset with FIFO count 3 and TIMER = 100 -> next cycle tx_valid = 0, irq = 0, CYCLE reads from 0, TIMER reads 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: passes dmem accesses through to the syncram and decodes the top of the
// word address space into a cycle counter, a one-shot down-timer and a TX byte FIFO.
module dmem_mmio_responder #(
    parameter logic [11:0] MMIO_BASE  = 12'hF00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    localparam logic [11:0] OffCycle  = 12'd0;
    localparam logic [11:0] OffTimer  = 12'd1;
    localparam logic [11:0] OffStatus = 12'd2;
    localparam logic [11:0] OffTx     = 12'd3;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        is_mmio;
    logic [11:0] offset;
    logic        mmio_wr;
    logic        wr_timer;
    logic        wr_status;
    logic        wr_tx;

    always_comb begin
        is_mmio   = (address_dmem >= MMIO_BASE);
        offset    = address_dmem - MMIO_BASE;
        // State updates from the bus are suppressed during the reset cycle.
        mmio_wr   = wren & is_mmio & ~reset;
        wr_timer  = mmio_wr & (offset == OffTimer);
        wr_status = mmio_wr & (offset == OffStatus);
        wr_tx     = mmio_wr & (offset == OffTx);
    end

    assign ram_address = address_dmem;
    assign ram_data    = data;
    assign ram_wren    = wren & ~is_mmio;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]     cycle_q;
    logic [31:0]     timer_q, timer_d;
    logic            irq_pending_q, irq_pending_d;
    logic            overflow_q, overflow_d;
    logic            timer_expire;

    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push_ok;

    logic            sel_q;
    logic [31:0]     mmio_q;
    logic [31:0]     status_word;
    logic [31:0]     rd_val;

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Down-timer and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        timer_d      = timer_q;
        timer_expire = 1'b0;
        if (wr_timer) begin
            timer_d = data;
        end else if (timer_q != 32'd0) begin
            timer_d      = timer_q - 32'd1;
            timer_expire = (timer_q == 32'd1);
        end
    end

    // Sets are applied after W1C clears so a coincident event is never lost.
    always_comb begin
        irq_pending_d = irq_pending_q;
        overflow_d    = overflow_q;
        if (wr_status && data[0]) begin
            irq_pending_d = 1'b0;
        end
        if (wr_status && data[3]) begin
            overflow_d = 1'b0;
        end
        if (timer_expire) begin
            irq_pending_d = 1'b1;
        end
        if (wr_tx && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q       <= '0;
            irq_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            irq_pending_q <= irq_pending_d;
            overflow_q    <= overflow_d;
        end
    end

    assign irq = irq_pending_q;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DepthCnt);
        pop        = ~fifo_empty & tx_ready;
        push_ok    = wr_tx & (~fifo_full | pop);
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= data[7:0];
        end
    end

    assign tx_data  = fifo_mem_q[rd_ptr_q];
    assign tx_valid = ~fifo_empty;

    // ------------------------------------------------------------------
    // Read path: one registered stage to match the syncram latency
    // ------------------------------------------------------------------
    always_comb begin
        status_word      = '0;
        status_word[0]   = irq_pending_q;
        status_word[1]   = fifo_full;
        status_word[2]   = fifo_empty;
        status_word[3]   = overflow_q;
        status_word[8:4] = 5'(count_q);
    end

    always_comb begin
        rd_val = '0;
        if (is_mmio) begin
            case (offset)
                OffCycle:  rd_val = cycle_q;
                OffTimer:  rd_val = timer_q;
                OffStatus: rd_val = status_word;
                default:   rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q  <= 1'b0;
            mmio_q <= '0;
        end else begin
            sel_q  <= is_mmio;
            mmio_q <= rd_val;
        end
    end

    assign q_dmem = sel_q ? mmio_q : ram_q;

endmodule
